// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: decode control + operands to execute, with hazard-unit stall/flush.
// Latency 1 cycle, no combinational in->out path; stall holds, flush (wins over stall) loads a NOP bubble.
// Optional ID_EX_BUBBLE_CNT_EN adds the bubble_cnt output counting inserted bubbles.
module id_ex_reg #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_e,
   input  logic            flush_e,
   input  logic            valid_d,
   input  logic            regwrite_d,
   input  logic [1:0]      resultsrc_d,
   input  logic            memwrite_d,
   input  logic            jump_d,
   input  logic            branch_d,
   input  logic [3:0]      alucontrol_d,
   input  logic            alusrc_d,
   input  logic [XLEN-1:0] rd1_d,
   input  logic [XLEN-1:0] rd2_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pcplus4_d,
   input  logic [XLEN-1:0] immext_d,
   input  logic [REGW-1:0] rs1_d,
   input  logic [REGW-1:0] rs2_d,
   input  logic [REGW-1:0] rd_d,
   output logic            valid_e,
   output logic            regwrite_e,
   output logic [1:0]      resultsrc_e,
   output logic            memwrite_e,
   output logic            jump_e,
   output logic            branch_e,
   output logic [3:0]      alucontrol_e,
   output logic            alusrc_e,
   output logic [XLEN-1:0] rd1_e,
   output logic [XLEN-1:0] rd2_e,
   output logic [XLEN-1:0] pc_e,
   output logic [XLEN-1:0] pcplus4_e,
   output logic [XLEN-1:0] immext_e,
   output logic [REGW-1:0] rs1_e,
   output logic [REGW-1:0] rs2_e,
`ifdef ID_EX_BUBBLE_CNT_EN
   output logic [REGW-1:0] rd_e,
   output logic [CNTW-1:0] bubble_cnt
`else
   output logic [REGW-1:0] rd_e
`endif
);

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic [1:0]      resultsrc;
      logic            memwrite;
      logic            jump;
      logic            branch;
      logic [3:0]      alucontrol;
      logic            alusrc;
   } ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcplus4;
      logic [XLEN-1:0] immext;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [REGW-1:0] rd;
   } data_t;

   ctrl_t ctrl_q, ctrl_nxt;
   data_t data_q, data_nxt;

   // An invalid slot still carries its data, but every side-effecting control is killed.
   always_comb begin
      ctrl_nxt            = '0;
      ctrl_nxt.valid      = valid_d;
      ctrl_nxt.regwrite   = regwrite_d & valid_d;
      ctrl_nxt.resultsrc  = resultsrc_d;
      ctrl_nxt.memwrite   = memwrite_d & valid_d;
      ctrl_nxt.jump       = jump_d & valid_d;
      ctrl_nxt.branch     = branch_d & valid_d;
      ctrl_nxt.alucontrol = alucontrol_d;
      ctrl_nxt.alusrc     = alusrc_d;
   end

   always_comb begin
      data_nxt         = '0;
      data_nxt.rd1     = rd1_d;
      data_nxt.rd2     = rd2_d;
      data_nxt.pc      = pc_d;
      data_nxt.pcplus4 = pcplus4_d;
      data_nxt.immext  = immext_d;
      data_nxt.rs1     = rs1_d;
      data_nxt.rs2     = rs2_d;
      data_nxt.rd      = rd_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else if (flush_e) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else if (!stall_e) begin
         ctrl_q <= ctrl_nxt;
         data_q <= data_nxt;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic bubble_ev;

   // Counts flushes plus loads of empty decode slots; stalls insert nothing new.
   assign bubble_ev = flush_e | (~stall_e & ~valid_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (bubble_ev) begin
         bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end
`endif

   assign valid_e      = ctrl_q.valid;
   assign regwrite_e   = ctrl_q.regwrite;
   assign resultsrc_e  = ctrl_q.resultsrc;
   assign memwrite_e   = ctrl_q.memwrite;
   assign jump_e       = ctrl_q.jump;
   assign branch_e     = ctrl_q.branch;
   assign alucontrol_e = ctrl_q.alucontrol;
   assign alusrc_e     = ctrl_q.alusrc;
   assign rd1_e        = data_q.rd1;
   assign rd2_e        = data_q.rd2;
   assign pc_e         = data_q.pc;
   assign pcplus4_e    = data_q.pcplus4;
   assign immext_e     = data_q.immext;
   assign rs1_e        = data_q.rs1;
   assign rs2_e        = data_q.rs2;
   assign rd_e         = data_q.rd;

endmodule
